// File: rtl/eth_frame_build.sv
// Builds an Ethernet/IPv4/UDP frame (no FCS) into the TX frame RAM from a word-aligned
// payload buffer, using the nibble-swapped stored-word format the RX parser consumes.
module eth_frame_build #(
  parameter logic [47:0] DST_MAC  = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01,
  parameter logic [31:0] SRC_IP   = 32'hC0A8010A,
  parameter logic [31:0] DST_IP   = 32'hC0A80101,
  parameter logic [15:0] SRC_PORT = 16'd5000,
  parameter logic [15:0] DST_PORT = 16'd5001,
  parameter logic [7:0]  TTL      = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  payload_words,
  output logic [9:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] wr_data,
  output logic [9:0]  wr_addr,
  output logic        wr_ena,
  output logic [9:0]  last_addr,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CKSUM, S_HDR, S_PAYLOAD, S_FLUSH, S_DONE
  } state_t;

  state_t      state_q;
  logic [7:0]  n_q;
  logic [15:0] id_q;
  logic [19:0] sum_q;
  logic [15:0] cksum_q;
  logic        step_q;
  logic [9:0]  cnt_q;
  logic [15:0] held_q;
  logic [9:0]  rd_addr_q;
  logic [31:0] wr_data_q;
  logic [9:0]  wr_addr_q;
  logic        wr_ena_q;
  logic [9:0]  last_addr_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0]  tot_len;
  logic [15:0]  udp_len;
  logic [19:0]  sum_d;
  logic [16:0]  fold1;
  logic [15:0]  fold2;
  logic [15:0]  cksum_d;
  logic [383:0] hdr_bits;
  logic [31:0]  hdr_w [16];
  logic [31:0]  pay_word_d;
  logic [15:0]  held_d;
  logic         rd_adv;
  logic [9:0]   last_pay;

  function automatic logic [7:0] nib(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction

  // Big-endian 4-byte chunk (first wire byte in [31:24]) -> stored word.
  function automatic logic [31:0] swap_word(input logic [31:0] c);
    return {nib(c[7:0]), nib(c[15:8]), nib(c[23:16]), nib(c[31:24])};
  endfunction

  always_comb begin
    tot_len = 16'd28 + {6'd0, n_q, 2'd0};
    udp_len = 16'd8 + {6'd0, n_q, 2'd0};
    sum_d   = 20'(16'h4500) + 20'(tot_len) + 20'(id_q) + 20'(16'h4000)
            + 20'({TTL, 8'h11})
            + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
            + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
    // Two folds suffice: a 20-bit sum folds to at most 0x1000E, whose fold cannot carry.
    fold1   = {1'b0, sum_q[15:0]} + {13'd0, sum_q[19:16]};
    fold2   = fold1[15:0] + {15'd0, fold1[16]};
    cksum_d = ~fold2;

    hdr_bits = {64'h55555555555555D5, DST_MAC, SRC_MAC, 16'h0800,
                16'h4500, tot_len, id_q, 16'h4000, TTL, 8'h11, cksum_q,
                SRC_IP, DST_IP,
                SRC_PORT, DST_PORT, udp_len};
    for (int unsigned i = 0; i < 16; i++) hdr_w[i] = '0;
    for (int unsigned i = 0; i < 12; i++) hdr_w[i] = swap_word(hdr_bits[383 - 32*i -: 32]);

    // Header ends 2 bytes into a word, so each payload word straddles two frame words.
    pay_word_d = {nib(rd_data[15:8]), nib(rd_data[7:0]), held_q};
    held_d     = {nib(rd_data[31:24]), nib(rd_data[23:16])};
    rd_adv     = (rd_addr_q + 10'd1) < {2'b0, n_q};
    last_pay   = {2'b0, n_q} + 10'd11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      id_q        <= '0;
      sum_q       <= '0;
      cksum_q     <= '0;
      step_q      <= 1'b0;
      cnt_q       <= '0;
      held_q      <= '0;
      rd_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      wr_ena_q    <= 1'b0;
      last_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          wr_ena_q <= 1'b0;
          if (start && !done_q) begin
            n_q       <= payload_words;
            busy_q    <= 1'b1;
            step_q    <= 1'b0;
            cnt_q     <= '0;
            held_q    <= '0;
            rd_addr_q <= '0;
            state_q   <= S_CKSUM;
          end
        end
        S_CKSUM: begin
          if (!step_q) begin
            sum_q  <= sum_d;
            step_q <= 1'b1;
          end else begin
            cksum_q <= cksum_d;
            state_q <= S_HDR;
          end
        end
        S_HDR: begin
          wr_data_q <= hdr_w[cnt_q[3:0]];
          wr_addr_q <= cnt_q;
          wr_ena_q  <= 1'b1;
          cnt_q     <= cnt_q + 10'd1;
          if (cnt_q == 10'd11) begin
            if (rd_adv) rd_addr_q <= rd_addr_q + 10'd1;
            state_q <= (n_q == 8'd0) ? S_FLUSH : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          wr_data_q <= pay_word_d;
          wr_addr_q <= cnt_q;
          wr_ena_q  <= 1'b1;
          held_q    <= held_d;
          cnt_q     <= cnt_q + 10'd1;
          if (rd_adv) rd_addr_q <= rd_addr_q + 10'd1;
          if (cnt_q == last_pay) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          wr_data_q <= {16'h0000, held_q};
          wr_addr_q <= cnt_q;
          wr_ena_q  <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          wr_ena_q    <= 1'b0;
          last_addr_q <= cnt_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          id_q        <= id_q + 16'd1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_addr   = rd_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_addr   = wr_addr_q;
  assign wr_ena    = wr_ena_q;
  assign last_addr = last_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_eth_frame_build.sv
// Randomized self-checking bench for eth_frame_build against a byte-level frame model.
module tb_eth_frame_build;

  localparam logic [47:0] P_DST_MAC  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] P_SRC_MAC  = 48'h02_00_00_00_00_01;
  localparam logic [31:0] P_SRC_IP   = 32'hC0A8010A;
  localparam logic [31:0] P_DST_IP   = 32'hC0A80101;
  localparam logic [15:0] P_SRC_PORT = 16'd5000;
  localparam logic [15:0] P_DST_PORT = 16'd5001;
  localparam logic [7:0]  P_TTL      = 8'd64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  payload_words = '0;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic [31:0] wr_data;
  logic [9:0]  wr_addr;
  logic        wr_ena;
  logic [9:0]  last_addr;
  logic        busy;
  logic        done;

  eth_frame_build #(
    .DST_MAC(P_DST_MAC), .SRC_MAC(P_SRC_MAC), .SRC_IP(P_SRC_IP), .DST_IP(P_DST_IP),
    .SRC_PORT(P_SRC_PORT), .DST_PORT(P_DST_PORT), .TTL(P_TTL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .payload_words(payload_words),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_data(wr_data), .wr_addr(wr_addr),
    .wr_ena(wr_ena), .last_addr(last_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] pmem [1024];
  always @(posedge clk) rd_data <= pmem[rd_addr];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  logic [9:0]  cap_addr [$];
  logic [31:0] cap_data [$];
  int          cap_cyc  [$];
  logic [9:0]  rd_log   [$];
  logic [7:0]  fb       [$];
  logic [31:0] exp_words [$];
  logic [15:0] exp_id = '0;

  always @(negedge clk) begin
    cyc++;
    if (wr_ena) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
      cap_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (busy && (rd_log.size() == 0 || rd_log[$] != rd_addr)) rd_log.push_back(rd_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_be(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) fb.push_back(v[8*i +: 8]);
  endtask

  function automatic logic [7:0] sw(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction

  // Frame as a list of wire bytes, then packed four at a time into stored words.
  task automatic build_model(input int n, input logic [15:0] id);
    int unsigned s;
    logic [15:0] ck;
    logic [31:0] pw;
    fb.delete();
    exp_words.delete();
    for (int i = 0; i < 7; i++) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    push_be(64'(P_DST_MAC), 6);
    push_be(64'(P_SRC_MAC), 6);
    push_be(64'h0800, 2);
    push_be(64'h4500, 2);
    push_be(64'(28 + 4 * n), 2);
    push_be(64'(id), 2);
    push_be(64'h4000, 2);
    push_be(64'(P_TTL), 1);
    push_be(64'h11, 1);
    push_be(64'h0000, 2);
    push_be(64'(P_SRC_IP), 4);
    push_be(64'(P_DST_IP), 4);
    s = 0;
    for (int h = 0; h < 10; h++) s += {16'h0, fb[22 + 2*h], fb[23 + 2*h]};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    ck = ~s[15:0];
    fb[32] = ck[15:8];
    fb[33] = ck[7:0];
    push_be(64'(P_SRC_PORT), 2);
    push_be(64'(P_DST_PORT), 2);
    push_be(64'(8 + 4 * n), 2);
    push_be(64'h0000, 2);
    for (int k = 0; k < n; k++) begin
      pw = pmem[k];
      for (int j = 0; j < 4; j++) fb.push_back(pw[8*j +: 8]);
    end
    fb.push_back(8'h00);
    fb.push_back(8'h00);
    for (int w = 0; w < fb.size() / 4; w++)
      exp_words.push_back({sw(fb[4*w+3]), sw(fb[4*w+2]), sw(fb[4*w+1]), sw(fb[4*w])});
  endtask

  task automatic run_frame(input int n, input bit fixed, input bit poke_busy,
                           input bit poke_done, input string tag);
    bit seen;
    int nrd;
    for (int k = 0; k < n; k++) pmem[k] = fixed ? 32'hDDCCBBAA : $urandom;
    build_model(n, exp_id);
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete(); rd_log.delete();
    done_cnt = 0;
    payload_words = n[7:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    payload_words = 8'($urandom);
    seen = 1'b0;
    for (int b = 0; b < 2000; b++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      start = poke_busy && (b == 5 || b == 20);
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_last_addr"}, 32'(last_addr), 32'(n + 12));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (poke_done && seen) begin
      start = 1'b1;
      payload_words = 8'd3;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_start_on_done_ignored"}, 32'(busy), 32'd0);
    end
    repeat (4) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_nwrites"}, 32'(cap_data.size()), 32'(n + 13));
    for (int i = 0; i < cap_data.size() && i < exp_words.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(cap_addr[i]), 32'(i));
      chk($sformatf("%s_word%0d", tag, i), cap_data[i], exp_words[i]);
    end
    if (cap_cyc.size() > 0)
      chk({tag, "_gapless"}, 32'(cap_cyc[$] - cap_cyc[0]), 32'(cap_cyc.size() - 1));
    nrd = (n == 0) ? 1 : n;
    chk({tag, "_rd_seq_len"}, 32'(rd_log.size()), 32'(nrd));
    for (int i = 0; i < rd_log.size() && i < nrd; i++)
      chk($sformatf("%s_rd%0d", tag, i), 32'(rd_log[i]), 32'(i));
    exp_id = exp_id + 16'd1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_ena"},    32'(wr_ena),    32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
    chk({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    chk({tag, "_wr_data"},   wr_data,        32'd0);
    chk({tag, "_last_addr"}, 32'(last_addr), 32'd0);
  endtask

  task automatic check_n1_constants(input string tag, input logic [31:0] w8);
    if (cap_data.size() >= 14) begin
      chk({tag, "_c_w0"},  cap_data[0],  32'h55555555);
      chk({tag, "_c_w1"},  cap_data[1],  32'h5D555555);
      chk({tag, "_c_w5"},  cap_data[5],  32'h00540080);
      chk({tag, "_c_w8"},  cap_data[8],  w8);
      chk({tag, "_c_w12"}, cap_data[12], 32'hBBAA0000);
      chk({tag, "_c_w13"}, cap_data[13], 32'h0000DDCC);
    end else begin
      chk({tag, "_c_size"}, 32'(cap_data.size()), 32'd14);
    end
  endtask

  initial begin
    int nrand;
    int ncap;
    bit reached;
    for (int i = 0; i < 1024; i++) pmem[i] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_frame(1, 1'b1, 1'b0, 1'b0, "n1_first");
    check_n1_constants("n1_first", 32'h8A0C177B);

    run_frame(1, 1'b1, 1'b0, 1'b1, "n1_second");
    check_n1_constants("n1_second", 32'h8A0C077B);

    run_frame(0, 1'b0, 1'b0, 1'b0, "n0");
    if (cap_data.size() > 12) chk("n0_word12_zero", cap_data[12], 32'h00000000);

    run_frame(255, 1'b0, 1'b1, 1'b0, "n255");

    for (int r = 0; r < 3; r++) begin
      nrand = $urandom_range(0, 40);
      run_frame(nrand, 1'b0, 1'b0, 1'b0, $sformatf("rand%0d", r));
    end

    // Abort mid-payload, then confirm the next frame restarts identification at 0.
    for (int k = 0; k < 8; k++) pmem[k] = $urandom;
    payload_words = 8'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int b = 0; b < 200; b++) begin
      @(negedge clk);
      if (wr_ena && wr_addr >= 10'd14) begin reached = 1'b1; break; end
    end
    chk("abort_reached_payload", 32'(reached), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    ncap = cap_data.size();
    repeat (3) @(negedge clk);
    chk("abort_no_writes", 32'(cap_data.size()), 32'(ncap));
    rst = 1'b0;
    exp_id = '0;
    @(negedge clk);
    run_frame(1, 1'b1, 1'b0, 1'b0, "after_abort");
    check_n1_constants("after_abort", 32'h8A0C177B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_frame_build.md
Name: eth_frame_build

Overview:
- Transmit-side counterpart of the RX frame parser.
- On a start pulse, reads a word-aligned UDP payload from a payload RAM. It then writes a complete Ethernet/IPv4/UDP frame into a TX frame RAM, in the same stored-word format the RX parser consumes.
- Frame content, in order: preamble/SFD, Ethernet header, 20-byte IPv4 header with computed checksum, UDP header, payload.
- No FCS. Sits between the application payload buffer and the TX frame RAM.

Parameters:
DST_MAC, 48'hFFFFFFFFFFFF, destination MAC.
SRC_MAC, 48'h02_00_00_00_00_01, source MAC.
SRC_IP, 32'hC0A8010A, source IPv4 (192.168.1.10).
DST_IP, 32'hC0A80101, destination IPv4 (192.168.1.1).
SRC_PORT, 16'd5000, UDP source port.
DST_PORT, 16'd5001, UDP destination port.
TTL, 8'd64, IPv4 time-to-live.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to build a frame; ignored while busy.
- payload_words  in  8  payload length N in 32-bit words (0..255); sampled when start is accepted.
- rd_addr  out  10  payload RAM read address; word k at address k.
- rd_data  in  32  payload RAM data; 1-cycle read latency; logical byte order, first byte in [7:0].
- wr_data  out  32  TX frame RAM write data.
- wr_addr  out  10  TX frame RAM write address.
- wr_ena  out  1  TX frame RAM write enable.
- last_addr  out  10  address of the final frame word; valid when done is high, held until next start.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final word is written.

Behaviour:
Reset:
- State goes to IDLE.
- rd_addr=0, wr_addr=0, wr_data=0, wr_ena=0, last_addr=0, busy=0, done=0.
- IP identification counter goes to 0.
- Reset mid-frame aborts immediately; no further writes occur.

Stored word format:
- Wire byte i of a word goes to bits [8i+7:8i]; the first wire byte is in [7:0].
- Each byte is nibble-swapped: stored {b[3:0], b[7:4]}.

Frame byte layout:
- Bytes 0-6: 0x55. Byte 7: 0xD5.
- Bytes 8-13: DST_MAC, MSB first. Bytes 14-19: SRC_MAC.
- Bytes 20-21: ethertype 08 00.
- IPv4 header, 20 bytes:
  - 45 00; total length = 28+4N.
  - identification = counter; flags/frag = 40 00 (DF).
  - TTL; protocol 0x11; header checksum.
  - SRC_IP; DST_IP.
- UDP header:
  - SRC_PORT; DST_PORT.
  - length = 8+4N.
  - checksum = 00 00.
- Payload bytes follow, then 2 zero pad bytes.
- All multibyte fields are big-endian on the wire.

Word counts and alignment:
- Total words = N+13; addresses 0..N+12; last_addr = N+12.
- Header is 50 bytes, so payload sits at a 2-byte offset.
- Frame word 12+k (k=0..N-1) = {payload[k] byte1, payload[k] byte0, prior 2 bytes}:
  - Prior bytes for k=0 are the UDP checksum bytes (00 00).
  - Otherwise they are bytes 2,3 of payload word k-1.
- Final word N+12 = {00, 00, held 2 bytes}.

FSM:
- IDLE: on start, latch N, busy<=1, go to CKSUM.
- CKSUM: 16-bit one's-complement sum of the ten IP header halfwords, with the checksum field taken as 0.
  - Fold carries until none remain, then invert.
  - Multi-cycle is allowed; at most 4 cycles.
  - Then go to HDR.
- HDR: write words 0..11 on consecutive cycles, wr_ena=1.
  - Issue rd_addr=0 no later than the last HDR cycle.
- PAYLOAD: write words 12..N+11 back-to-back, one per cycle, no gaps.
  - rd_addr advances one word ahead to cover the 1-cycle read latency.
  - Skipped when N=0.
- FLUSH: write word N+12.
- DONE: wr_ena=0, last_addr=N+12, done=1 for one cycle, busy<=0.
  - Increment identification by 1; it wraps at 16'hFFFF to 0.
  - Go to IDLE.

Other rules:
- wr_ena is high only in HDR/PAYLOAD/FLUSH; wr_addr increments by 1 per written word.
- start in the same cycle as done is ignored.
- start while busy has no effect.

Test Plan:
- N=1, payload word 0xDDCCBBAA, first frame → 14 words written to addresses 0..13; done pulses once; last_addr=13. Required words:
  - word0=0x55555555, word1=0x5D555555.
  - word5=0x00540080.
  - word8=0x8A0C177B (IP checksum 0xB771).
  - word12=0xBBAA0000 with the nibble swap applied to each byte (stored 0xBBAA0000).
  - word13=0x0000DDCC with the nibble swap applied (stored 0x0000DDCC).
- N=0 → 13 words; last_addr=12; UDP length=8; IP total length=28; word12 stored 0x00000000.
- N=255 → 268 writes with no wr_ena gaps from HDR through FLUSH; last_addr=267; rd_addr sequence 0..254.
- Two back-to-back frames with N=1 → second frame's identification=0x0001; its checksum recomputed as 0xB770 (word8=0x8A0C077B).
- Assert rst mid-PAYLOAD → next cycle wr_ena=0, busy=0, all outputs at reset values; a following start (N=1) produces the correct 14-word frame with identification 0.
- Pulse start again while busy → ignored: exactly one frame is written and one done pulse occurs.
